move_scheduler: RTL

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/move_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/move_scheduler.sv
// move_scheduler: once per game tick, steps pacman and three monsters in turn.
// Each mover gets a candidate coordinate, a shared maze-wall lookup, and a commit
// if the candidate is not a wall; a collision check ends every step.
// Optional feature: define MOVE_TIMEOUT_EN to abandon a wall lookup that sees
// no wq_ready for 16 cycles (position kept, sequence continues).
module move_scheduler #(
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239,
    parameter int STEP  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] btn,
    input  logic [1:0] m1_dir,
    input  logic [1:0] m2_dir,
    input  logic [1:0] m3_dir,
    output logic       wq_valid,
    output logic [8:0] wq_x,
    output logic [8:0] wq_y,
    input  logic       wq_ready,
    input  logic       wq_wall,
    output logic [8:0] p_x,
    output logic [8:0] p_y,
    output logic [8:0] m1_x,
    output logic [8:0] m1_y,
    output logic [8:0] m2_x,
    output logic [8:0] m2_y,
    output logic [8:0] m3_x,
    output logic [8:0] m3_y,
    output logic       busy,
    output logic       done,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEL     = 3'd1,
        REQ     = 3'd2,
        COMMIT  = 3'd3,
        COLLIDE = 3'd4,
        OVER    = 3'd5
    } state_t;

    // Direction encoding shared by monsters and the decoded pacman buttons.
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Arithmetic is done one bit wider than the coordinate so that a step past
    // zero shows up as bit 9 set rather than wrapping to a large legal value.
    localparam logic [9:0] W_STEP = 10'(STEP);
    localparam logic [9:0] W_XMAX = 10'(X_MAX);
    localparam logic [9:0] W_YMAX = 10'(Y_MAX);

    // Start positions: pacman below the monster pen, monsters side by side.
    localparam logic [8:0] P_X0  = 9'd160;
    localparam logic [8:0] P_Y0  = 9'd180;
    localparam logic [8:0] M1_X0 = 9'd144;
    localparam logic [8:0] M2_X0 = 9'd160;
    localparam logic [8:0] M3_X0 = 9'd176;
    localparam logic [8:0] M_Y0  = 9'd120;

    state_t     r_state;
    state_t     w_next_state;
    state_t     w_after;
    logic [1:0] r_idx;
    logic [8:0] r_pos_x [0:3];
    logic [8:0] r_pos_y [0:3];
    logic [8:0] r_cand_x;
    logic [8:0] r_cand_y;
    logic       r_wall;
    logic       r_done;
    logic       r_game_over;

    logic       w_move;
    logic [1:0] w_dir;
    logic [8:0] w_cur_x;
    logic [8:0] w_cur_y;
    logic [9:0] w_ext_x;
    logic [9:0] w_ext_y;
    logic [9:0] w_dec_x;
    logic [9:0] w_dec_y;
    logic [9:0] w_inc_x;
    logic [9:0] w_inc_y;
    logic [8:0] w_cand_x;
    logic [8:0] w_cand_y;
    logic       w_cand_ok;
    logic       w_hit;
    logic       w_timeout;
    logic       w_adv;

    // Position of whichever entity is currently being processed.
    assign w_cur_x = r_pos_x[r_idx];
    assign w_cur_y = r_pos_y[r_idx];
    assign w_ext_x = {1'b0, w_cur_x};
    assign w_ext_y = {1'b0, w_cur_y};
    assign w_dec_x = w_ext_x - W_STEP;
    assign w_dec_y = w_ext_y - W_STEP;
    assign w_inc_x = w_ext_x + W_STEP;
    assign w_inc_y = w_ext_y + W_STEP;

    // Pick the direction for the indexed entity; pacman uses up>down>left>right.
    always_comb begin
        w_move = 1'b1;
        w_dir  = DIR_UP;
        case (r_idx)
            2'd0: begin
                if (btn[0]) begin
                    w_dir = DIR_UP;
                end else if (btn[1]) begin
                    w_dir = DIR_DOWN;
                end else if (btn[2]) begin
                    w_dir = DIR_LEFT;
                end else if (btn[3]) begin
                    w_dir = DIR_RIGHT;
                end else begin
                    w_move = 1'b0;
                    w_dir  = DIR_UP;
                end
            end
            2'd1:    w_dir = m1_dir;
            2'd2:    w_dir = m2_dir;
            default: w_dir = m3_dir;
        endcase
    end

    // Candidate coordinate and its legality (inside the field, no wrap-around).
    always_comb begin
        w_cand_x  = w_cur_x;
        w_cand_y  = w_cur_y;
        w_cand_ok = 1'b0;
        if (w_move) begin
            case (w_dir)
                DIR_UP: begin
                    w_cand_y  = w_dec_y[8:0];
                    w_cand_ok = ~w_dec_y[9];
                end
                DIR_DOWN: begin
                    w_cand_y  = w_inc_y[8:0];
                    w_cand_ok = (w_inc_y <= W_YMAX);
                end
                DIR_LEFT: begin
                    w_cand_x  = w_dec_x[8:0];
                    w_cand_ok = ~w_dec_x[9];
                end
                default: begin
                    w_cand_x  = w_inc_x[8:0];
                    w_cand_ok = (w_inc_x <= W_XMAX);
                end
            endcase
        end else begin
            w_cand_ok = 1'b0;
        end
    end

    // Pacman caught by any monster at exactly the same coordinate.
    assign w_hit = ((r_pos_x[0] == r_pos_x[1]) && (r_pos_y[0] == r_pos_y[1])) ||
                   ((r_pos_x[0] == r_pos_x[2]) && (r_pos_y[0] == r_pos_y[2])) ||
                   ((r_pos_x[0] == r_pos_x[3]) && (r_pos_y[0] == r_pos_y[3]));

`ifdef MOVE_TIMEOUT_EN
    logic [3:0] r_to_cnt;

    // Count consecutive REQ cycles that have gone without wq_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= 4'd0;
        end else if ((r_state == REQ) && !wq_ready) begin
            r_to_cnt <= r_to_cnt + 4'd1;
        end else begin
            r_to_cnt <= 4'd0;
        end
    end

    // The 16th unanswered REQ cycle gives up on the lookup.
    assign w_timeout = (r_state == REQ) && !wq_ready && (r_to_cnt == 4'd15);
`else
    assign w_timeout = 1'b0;
`endif

    // Move on to the next entity: skipped candidate, finished commit, or abandoned lookup.
    assign w_adv = ((r_state == SEL) && !w_cand_ok) ||
                   (r_state == COMMIT) ||
                   ((r_state == REQ) && !wq_ready && w_timeout);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; leaving an entity goes to the next SEL or, after the last, to COLLIDE.
    always_comb begin
        w_next_state = r_state;
        if (r_idx == 2'd3) begin
            w_after = COLLIDE;
        end else begin
            w_after = SEL;
        end
        case (r_state)
            IDLE: begin
                if (tick) begin
                    w_next_state = SEL;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SEL: begin
                if (w_cand_ok) begin
                    w_next_state = REQ;
                end else begin
                    w_next_state = w_after;
                end
            end
            REQ: begin
                if (wq_ready) begin
                    w_next_state = COMMIT;
                end else if (w_timeout) begin
                    w_next_state = w_after;
                end else begin
                    w_next_state = REQ;
                end
            end
            COMMIT: w_next_state = w_after;
            COLLIDE: begin
                if (w_hit) begin
                    w_next_state = OVER;
                end else begin
                    w_next_state = IDLE;
                end
            end
            OVER:    w_next_state = OVER;
            default: w_next_state = IDLE;
        endcase
    end

    // Entity index: cleared at step start, advanced as each entity finishes (wraps to 0 after 3).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= 2'd0;
        end else if ((r_state == IDLE) && tick) begin
            r_idx <= 2'd0;
        end else if (w_adv) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Latch the candidate in SEL so the lookup address stays stable through REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand_x <= 9'd0;
            r_cand_y <= 9'd0;
        end else if (r_state == SEL) begin
            r_cand_x <= w_cand_x;
            r_cand_y <= w_cand_y;
        end
    end

    // Capture the wall answer on the handshake cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wall <= 1'b0;
        end else if ((r_state == REQ) && wq_ready) begin
            r_wall <= wq_wall;
        end
    end

    // Entity positions: only COMMIT of a non-wall candidate changes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos_x[0] <= P_X0;
            r_pos_y[0] <= P_Y0;
            r_pos_x[1] <= M1_X0;
            r_pos_y[1] <= M_Y0;
            r_pos_x[2] <= M2_X0;
            r_pos_y[2] <= M_Y0;
            r_pos_x[3] <= M3_X0;
            r_pos_y[3] <= M_Y0;
        end else if ((r_state == COMMIT) && !r_wall) begin
            r_pos_x[r_idx] <= r_cand_x;
            r_pos_y[r_idx] <= r_cand_y;
        end
    end

    // Completion pulse and sticky game-over flag, both decided in COLLIDE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_done      <= (r_state == COLLIDE) && !w_hit;
            r_game_over <= r_game_over | ((r_state == COLLIDE) && w_hit);
        end
    end

    assign wq_valid  = (r_state == REQ);
    assign wq_x      = r_cand_x;
    assign wq_y      = r_cand_y;
    assign busy      = (r_state != IDLE) && (r_state != OVER);
    assign done      = r_done;
    assign game_over = r_game_over;

    assign p_x  = r_pos_x[0];
    assign p_y  = r_pos_y[0];
    assign m1_x = r_pos_x[1];
    assign m1_y = r_pos_y[1];
    assign m2_x = r_pos_x[2];
    assign m2_y = r_pos_y[2];
    assign m3_x = r_pos_x[3];
    assign m3_y = r_pos_y[3];

endmodule
